// File: rtl/csr_access_unit.sv
// Zicsr executor: reads the addressed CSR, applies RW/RS/RC, writes back when
// required and returns the old value for rd; rejects bad funct3 / read-only writes.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for req; csr_addr parked at 0
// S_READ  | csr_addr driven, csr_readbus sampled, legality decided
// S_WRITE | one-cycle csr_we strobe with the new value
// S_DONE  | done pulse; rd_* and illegal valid
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_i,
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_sel_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [4:0]      rd_idx_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            illegal_o,
  output logic            rd_we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            csr_we_o,
  input  logic [XLEN-1:0] csr_readbus_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     addr_q, addr_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic [XLEN-1:0] old_q, old_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic            rd_we_q, rd_we_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [11:0]     csr_addr_q, csr_addr_d;
  logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;
  logic            csr_we_q, csr_we_d;

  // Decode of the latched instruction against the value on the read bus.
  logic            op_rw, op_rs, op_rc, bad_funct3;
  logic            write_req, ro_space, access_illegal;
  logic [XLEN-1:0] new_val;

  always_comb begin
    op_rw      = (funct3_q[1:0] == 2'b01);
    op_rs      = (funct3_q[1:0] == 2'b10);
    op_rc      = (funct3_q[1:0] == 2'b11);
    bad_funct3 = (funct3_q[1:0] == 2'b00);
    // Suppression follows the rs1 field, not the operand value.
    write_req  = op_rw | ((op_rs | op_rc) & (rs1_idx_q != 5'd0));
    ro_space   = (addr_q[11:10] == 2'b11);
    access_illegal = bad_funct3 | (write_req & ro_space);

    new_val = csr_readbus_i;
    if (op_rw) begin
      new_val = operand_q;
    end else if (op_rs) begin
      new_val = csr_readbus_i | operand_q;
    end else if (op_rc) begin
      new_val = csr_readbus_i & ~operand_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    rd_idx_d    = rd_idx_q;
    rs1_idx_d   = rs1_idx_q;
    operand_d   = operand_q;
    old_d       = old_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    rd_we_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_we_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d     = 1'b0;
        csr_addr_d = 12'd0;
        if (req_i) begin
          funct3_d   = funct3_i;
          addr_d     = csr_sel_i;
          rd_idx_d   = rd_idx_i;
          rs1_idx_d  = rs1_idx_i;
          operand_d  = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;
          busy_d     = 1'b1;
          csr_addr_d = csr_sel_i;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        old_d = csr_readbus_i;
        if (access_illegal || !write_req) begin
          done_d     = 1'b1;
          illegal_d  = access_illegal;
          rd_we_d    = !access_illegal && (rd_idx_q != 5'd0);
          rd_addr_d  = rd_idx_q;
          rd_data_d  = access_illegal ? '0 : csr_readbus_i;
          csr_addr_d = 12'd0;
          state_d    = S_DONE;
        end else begin
          csr_we_d    = 1'b1;
          csr_wdata_d = new_val;
          state_d     = S_WRITE;
        end
      end

      S_WRITE: begin
        done_d     = 1'b1;
        rd_we_d    = (rd_idx_q != 5'd0);
        rd_addr_d  = rd_idx_q;
        rd_data_d  = old_q;
        csr_addr_d = 12'd0;
        state_d    = S_DONE;
      end

      S_DONE: begin
        // req is deliberately not sampled here.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d     = 1'b0;
        csr_addr_d = 12'd0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      funct3_q    <= 3'd0;
      addr_q      <= 12'd0;
      rd_idx_q    <= 5'd0;
      rs1_idx_q   <= 5'd0;
      operand_q   <= '0;
      old_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= 5'd0;
      rd_data_q   <= '0;
      csr_addr_q  <= 12'd0;
      csr_wdata_q <= '0;
      csr_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      rd_idx_q    <= rd_idx_d;
      rs1_idx_q   <= rs1_idx_d;
      operand_q   <= operand_d;
      old_q       <= old_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_we_q    <= csr_we_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign illegal_o   = illegal_q;
  assign rd_we_o     = rd_we_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign csr_addr_o  = csr_addr_q;
  assign csr_wdata_o = csr_wdata_q;
  assign csr_we_o    = csr_we_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: CSR file model, transaction-level reference model
// with a per-cycle compare, and directed instructions with literal expectations.
module tb_csr_access_unit;

  logic        clk, reset, req;
  logic [2:0]  funct3;
  logic [11:0] csr_sel;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_idx, rd_idx;
  logic        busy, done, illegal, rd_we, csr_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, csr_wdata, csr_readbus;
  logic [11:0] csr_addr;

  int checks = 0;
  int errors = 0;

  csr_access_unit #(.XLEN(32)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .funct3_i(funct3),
    .csr_sel_i(csr_sel), .rs1_data_i(rs1_data), .rs1_idx_i(rs1_idx),
    .rd_idx_i(rd_idx), .busy_o(busy), .done_o(done), .illegal_o(illegal),
    .rd_we_o(rd_we), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata), .csr_we_o(csr_we),
    .csr_readbus_i(csr_readbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file: combinational read, written by the DUT strobe or by a preload port.
  logic [31:0] csr_mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  assign csr_readbus = csr_mem[csr_addr];

  always @(posedge clk) begin
    if (pre_we) csr_mem[pre_addr] <= pre_data;
    else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one record per accepted instruction, advanced by cycle count.
  int          m_k = 0;
  int          m_lat = 0;
  logic [11:0] m_sel;
  logic [31:0] m_new, m_rdata;
  bit          m_ill, m_rdwe;
  logic [4:0]  m_rdaddr;

  function automatic void model_op(input logic [2:0] f3, input logic [11:0] sel,
                                   input logic [31:0] d, input logic [4:0] rs1,
                                   input logic [31:0] old, output bit wr,
                                   output logic [31:0] nv, output bit ill);
    logic [31:0] opnd;
    opnd = f3[2] ? {27'd0, rs1} : d;
    wr = 1'b0;
    nv = old;
    case (f3[1:0])
      2'b01: begin wr = 1'b1; nv = opnd; end
      2'b10: begin wr = (rs1 != 0); nv = old | opnd; end
      2'b11: begin wr = (rs1 != 0); nv = old & ~opnd; end
      default: ;
    endcase
    ill = (f3[1:0] == 2'b00) || (wr && sel[11:10] == 2'b11);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k = 0;
    end else if (m_k != 0) begin
      m_k = (m_k == m_lat) ? 0 : m_k + 1;
    end else if (req) begin
      bit wr, ill;
      logic [31:0] nv, old;
      old = csr_mem[csr_sel];
      model_op(funct3, csr_sel, rs1_data, rs1_idx, old, wr, nv, ill);
      m_sel    = csr_sel;
      m_new    = nv;
      m_ill    = ill;
      m_lat    = (wr && !ill) ? 3 : 2;
      m_rdata  = ill ? 32'd0 : old;
      m_rdwe   = !ill && (rd_idx != 0);
      m_rdaddr = rd_idx;
      m_k      = 1;
    end
  end

  always @(negedge clk) begin
    if (m_k == 0) begin
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_csr_we", {31'd0, csr_we}, 32'd0);
      chk("idle_csr_addr", {20'd0, csr_addr}, 32'd0);
      chk("idle_rd_we", {31'd0, rd_we}, 32'd0);
      chk("idle_illegal", {31'd0, illegal}, 32'd0);
    end else begin
      chk("busy", {31'd0, busy}, 32'd1);
      if (m_k == m_lat) begin
        chk("done", {31'd0, done}, 32'd1);
        chk("done_csr_we", {31'd0, csr_we}, 32'd0);
        chk("done_illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("done_rd_we", {31'd0, rd_we}, {31'd0, m_rdwe});
        chk("done_rd_addr", {27'd0, rd_addr}, {27'd0, m_rdaddr});
        chk("done_rd_data", rd_data, m_rdata);
      end else if (m_k == 1) begin
        chk("read_csr_addr", {20'd0, csr_addr}, {20'd0, m_sel});
        chk("read_csr_we", {31'd0, csr_we}, 32'd0);
        chk("read_done", {31'd0, done}, 32'd0);
      end else begin
        chk("write_csr_we", {31'd0, csr_we}, 32'd1);
        chk("write_csr_wdata", csr_wdata, m_new);
        chk("write_csr_addr", {20'd0, csr_addr}, {20'd0, m_sel});
        chk("write_done", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [11:0] sel, input logic [31:0] d,
                       input logic [4:0] rs1, input logic [4:0] rd);
    funct3 = f3; csr_sel = sel; rs1_data = d; rs1_idx = rs1; rd_idx = rd;
  endtask

  // Issue one instruction and pin latency and done-time results to literals.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [11:0] sel,
                        input logic [31:0] d, input logic [4:0] rs1, input logic [4:0] rd,
                        input int exp_lat, input logic [31:0] exp_rdata, input bit exp_ill);
    int cyc;
    @(negedge clk);
    drive(f3, sel, d, rs1, rd);
    req = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy) req = 1'b0;
      if (done || cyc > 20) break;
    end
    req = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", nm, cyc);
    end else begin
      chk({nm, "_latency"}, cyc, exp_lat);
      chk({nm, "_rd_data"}, rd_data, exp_rdata);
      chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
      chk({nm, "_rd_we"}, {31'd0, rd_we}, {31'd0, (!exp_ill && rd != 0)});
      chk({nm, "_rd_addr"}, {27'd0, rd_addr}, {27'd0, rd});
    end
  endtask

  task automatic wait_neg(input string nm, input int which, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if ((which == 0 && busy) || (which == 1 && done) || (which == 2 && csr_we)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: event %0d not seen", nm, which);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int idle;
    reset = 1'b1; req = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive(3'b000, 12'h000, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
    preload(12'h340, 32'h12345678);
    preload(12'hF10, 32'h80100100);
    preload(12'hF14, 32'h00000000);
    preload(12'h300, 32'hFFFF00FF);
    preload(12'h341, 32'h11112222);
    preload(12'h305, 32'h0000F0F0);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    reset = 1'b0;

    run_op("csrrw_340", 3'b001, 12'h340, 32'hDEADBEEF, 5'd9, 5'd5, 3, 32'h12345678, 1'b0);
    chk("mem_340", csr_mem[12'h340], 32'hDEADBEEF);
    run_op("csrrs_misa", 3'b010, 12'hF10, 32'h0, 5'd0, 5'd3, 2, 32'h80100100, 1'b0);
    run_op("csrrw_hartid", 3'b001, 12'hF14, 32'h5555, 5'd1, 5'd7, 2, 32'h0, 1'b1);
    run_op("csrrci_300", 3'b111, 12'h300, 32'hFFFFFFFF, 5'h1F, 5'd4, 3, 32'hFFFF00FF, 1'b0);
    chk("mem_300", csr_mem[12'h300], 32'hFFFF00E0);
    run_op("csrrsi_zero", 3'b110, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd6, 2, 32'hFFFF00E0, 1'b0);
    run_op("funct3_100", 3'b100, 12'h300, 32'h0, 5'd1, 5'd8, 2, 32'h0, 1'b1);
    run_op("funct3_000", 3'b000, 12'h305, 32'h1, 5'd1, 5'd8, 2, 32'h0, 1'b1);
    run_op("csrrs_zero_data", 3'b010, 12'h305, 32'h0, 5'd4, 5'd10, 3, 32'h0000F0F0, 1'b0);
    run_op("csrrc_rd0", 3'b011, 12'h305, 32'h000000F0, 5'd2, 5'd0, 3, 32'h0000F0F0, 1'b0);
    chk("mem_305", csr_mem[12'h305], 32'h0000F000);
    run_op("csrrc_ro_nowrite", 3'b011, 12'hF10, 32'h0, 5'd0, 5'd11, 2, 32'h80100100, 1'b0);
    run_op("csrrsi_ro", 3'b110, 12'hF14, 32'h0, 5'd3, 5'd12, 2, 32'h0, 1'b1);

    // Reset landing in the WRITE cycle must abort the write.
    @(negedge clk);
    drive(3'b001, 12'h341, 32'hCAFEF00D, 5'd2, 5'd1);
    req = 1'b1;
    wait_neg("rst_wait_busy", 0, ok);
    req = 1'b0;
    wait_neg("rst_wait_we", 2, ok);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_csr_we", {31'd0, csr_we}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_mem", csr_mem[12'h341], 32'h11112222);
    reset = 1'b0;
    run_op("csrrw_after_rst", 3'b001, 12'h341, 32'hCAFEF00D, 5'd2, 5'd1, 3, 32'h11112222, 1'b0);
    chk("mem_341", csr_mem[12'h341], 32'hCAFEF00D);

    // req held high across two instructions: exactly one IDLE cycle between.
    @(negedge clk);
    drive(3'b001, 12'h341, 32'h000000AA, 5'd3, 5'd1);
    req = 1'b1;
    wait_neg("b2b_busy_a", 0, ok);
    drive(3'b010, 12'h341, 32'h0, 5'd0, 5'd2);
    wait_neg("b2b_done_a", 1, ok);
    chk("b2b_a_rd_data", rd_data, 32'hCAFEF00D);
    idle = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy) break;
      idle++;
    end
    chk("b2b_idle_gap", idle, 1);
    req = 1'b0;
    wait_neg("b2b_done_b", 1, ok);
    chk("b2b_b_rd_data", rd_data, 32'h000000AA);
    chk("b2b_b_rd_addr", {27'd0, rd_addr}, 32'd2);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
